// File: rtl/mux_2_1_arbiter.sv
// Round-robin, burst-locked arbiter that shares one W-bit port between two requesters.
// Optional beat limit under contention is enabled by defining ARB_BURST_LIMIT_EN.
module mux_2_1_arbiter #(
  parameter int unsigned W         = 32,
  parameter int unsigned MAX_BEATS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in0_valid,
  input  logic [W-1:0] in0_data,
  input  logic         in0_last,
  output logic         in0_ready,
  input  logic         in1_valid,
  input  logic [W-1:0] in1_data,
  input  logic         in1_last,
  output logic         in1_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic [1:0]   gnt,
  output logic         sel
);

  if (MAX_BEATS < 1 || MAX_BEATS > 255) begin : g_bad_max_beats
    $error("MAX_BEATS must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   rr, rr_nxt;
  logic   xfer;
  logic   burst_end;
  logic   handover;

  // Grant and select come straight from the state register.
  assign gnt      = {state == GNT1, state == GNT0};
  assign sel      = (state == GNT1);
  assign out_data = sel ? in1_data : in0_data;

  // Handshake steering for the granted requester.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    unique case (state)
      GNT0: begin
        out_valid = in0_valid;
        out_last  = in0_last;
        in0_ready = out_ready;
      end
      GNT1: begin
        out_valid = in1_valid;
        out_last  = in1_last;
        in1_ready = out_ready;
      end
      default: ;
    endcase
  end

  assign xfer      = out_valid & out_ready;
  assign burst_end = xfer & out_last;

`ifdef ARB_BURST_LIMIT_EN
  localparam logic [8:0] BEAT_LIMIT = 9'(MAX_BEATS);

  logic [7:0] beat_cnt, beat_cnt_nxt;
  logic       other_valid;
  logic       limit_hit;

  assign other_valid = (state == GNT0) ? in1_valid :
                       (state == GNT1) ? in0_valid : 1'b0;
  // Force a handover once the grant has used its beat budget and the other side waits.
  assign limit_hit   = other_valid &&
                       (({1'b0, beat_cnt} >= BEAT_LIMIT) ||
                        (xfer && (({1'b0, beat_cnt} + 9'd1) >= BEAT_LIMIT)));
  assign handover    = burst_end | limit_hit;

  always_comb begin
    beat_cnt_nxt = beat_cnt;
    if (state_nxt != state) beat_cnt_nxt = 8'd0;
    else if (xfer && beat_cnt != 8'hFF) beat_cnt_nxt = beat_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_cnt <= 8'd0;
    else        beat_cnt <= beat_cnt_nxt;
  end
`else
  assign handover = burst_end;
`endif

  // The served requester's valid is consumed by its last beat, so only the other side can take over.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    unique case (state)
      IDLE: begin
        if (in0_valid && in1_valid) state_nxt = rr ? GNT1 : GNT0;
        else if (in0_valid)         state_nxt = GNT0;
        else if (in1_valid)         state_nxt = GNT1;
      end
      GNT0: begin
        if (handover) begin
          rr_nxt    = 1'b1;
          state_nxt = in1_valid ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (handover) begin
          rr_nxt    = 1'b0;
          state_nxt = in0_valid ? GNT0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr    <= 1'b0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_mux_2_1_arbiter.sv
// Randomized and directed bench for mux_2_1_arbiter against a queue-based owner/round-robin model.
module tb_mux_2_1_arbiter;
  localparam int unsigned W    = 32;
  localparam int unsigned MAXB = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in0_valid, in0_last, in0_ready;
  logic         in1_valid, in1_last, in1_ready;
  logic [W-1:0] in0_data, in1_data, out_data;
  logic         out_valid, out_last, out_ready;
  logic [1:0]   gnt;
  logic         sel;

  mux_2_1_arbiter #(.W(W), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .gnt(gnt), .sel(sel)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [W-1:0] d; logic l; } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  bit    pres0, pres1, hold0, hold1;
  int    owner, owner_n;   // -1 = nobody, else requester index
  bit    rr, rr_n;
  int    cnt, cnt_n;
  bit    acc0, acc1;
  int    tests = 0;
  int    fails = 0;

  logic [1:0]   obs_gnt;
  logic         obs_ov, obs_sel, obs_r0, obs_r1;
  logic [W-1:0] obs_od;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive_inputs();
    in0_valid = pres0 && (q0.size() > 0);
    in1_valid = pres1 && (q1.size() > 0);
    if (q0.size() > 0) begin in0_data = q0[0].d; in0_last = q0[0].l; end
    else begin in0_data = $urandom; in0_last = 1'($urandom_range(0, 1)); end
    if (q1.size() > 0) begin in1_data = q1[0].d; in1_last = q1[0].l; end
    else begin in1_data = $urandom; in1_last = 1'($urandom_range(0, 1)); end
  endtask

  // Compare DUT against the model for this cycle and work out the model's next owner.
  task automatic check_cycle();
    logic         v0, v1, ev, el, er0, er1, es, xf, hand, ov_other;
    logic [1:0]   eg;
    logic [W-1:0] ed;
    int           other;
    v0 = in0_valid; v1 = in1_valid;
    ev = 1'b0; el = 1'b0; er0 = 1'b0; er1 = 1'b0; eg = 2'b00; es = 1'b0; ed = in0_data;
    if (owner == 0) begin
      ev = v0; el = in0_last; er0 = out_ready; eg = 2'b01;
    end else if (owner == 1) begin
      ev = v1; el = in1_last; er1 = out_ready; eg = 2'b10; es = 1'b1; ed = in1_data;
    end
    chk("gnt", 64'(gnt), 64'(eg));
    chk("sel", 64'(sel), 64'(es));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_last", 64'(out_last), 64'(el));
    chk("out_data", 64'(out_data), 64'(ed));
    chk("in0_ready", 64'(in0_ready), 64'(er0));
    chk("in1_ready", 64'(in1_ready), 64'(er1));
    obs_gnt = gnt; obs_ov = out_valid; obs_sel = sel; obs_r0 = in0_ready; obs_r1 = in1_ready;
    obs_od = out_data;
    acc0 = v0 & er0;
    acc1 = v1 & er1;
    owner_n = owner; rr_n = rr; cnt_n = cnt;
    if (!rst_n) begin
      owner_n = -1; rr_n = 1'b0; cnt_n = 0;
    end else if (owner < 0) begin
      if (v0 && v1) owner_n = int'(rr);
      else if (v0)  owner_n = 0;
      else if (v1)  owner_n = 1;
    end else begin
      other    = 1 - owner;
      ov_other = (other == 1) ? v1 : v0;
      xf       = ev & out_ready;
      hand     = xf & el;
`ifdef ARB_BURST_LIMIT_EN
      if (ov_other && (cnt >= int'(MAXB) || (xf && cnt + 1 >= int'(MAXB)))) hand = 1'b1;
`endif
      if (hand) begin
        rr_n    = 1'(other);
        owner_n = ov_other ? other : -1;
        cnt_n   = 0;
      end else if (xf && cnt < 255) begin
        cnt_n = cnt + 1;
      end
    end
  endtask

  task automatic commit();
    hold0 = in0_valid && !acc0;
    hold1 = in1_valid && !acc1;
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
    owner = owner_n; rr = rr_n; cnt = cnt_n;
  endtask

  task automatic cycle();
    drive_inputs();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    commit();
  endtask

  task automatic push(input int r, input logic [W-1:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l;
    if (r == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic push_burst(input int r);
    int n;
    n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) push(r, $urandom, 1'(i == n - 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   exp_cont[8];
    logic [1:0]   exp_single[5];
    logic [W-1:0] exp_a[5];
    owner = -1; rr = 1'b0; cnt = 0; acc0 = 1'b0; acc1 = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
    rst_n = 1'b0; out_ready = 1'b1;

    // Reset with both requesters pending, then two-beat bursts contending.
    for (int i = 0; i < 4; i++) push(0, W'(32'h100 + i), 1'(i % 2));
    for (int i = 0; i < 2; i++) push(1, W'(32'h200 + i), 1'(i % 2));
    pres0 = 1; pres1 = 1;
    #1;
    repeat (2) begin
      cycle();
      chk("reset_gnt", 64'(obs_gnt), 64'h0);
      chk("reset_valid", 64'(obs_ov), 64'h0);
      chk("reset_ready", 64'({obs_r0, obs_r1}), 64'h0);
    end
    rst_n = 1'b1;
    exp_cont = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("contention_gnt", 64'(obs_gnt), 64'(exp_cont[i]));
    end

    // Lone requester 1 burst of three beats.
    push(1, 32'hA1, 1'b0); push(1, 32'hA2, 1'b0); push(1, 32'hA3, 1'b1);
    exp_single = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
    exp_a      = '{32'h0, 32'hA1, 32'hA2, 32'hA3, 32'h0};
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("single_gnt", 64'(obs_gnt), 64'(exp_single[i]));
      if (i >= 1 && i <= 3) begin
        chk("single_data", 64'(obs_od), 64'(exp_a[i]));
        chk("single_sel", 64'(obs_sel), 64'h1);
      end
    end

    // Tie right after requester 1 was served: pointer must favour requester 0.
    push(0, 32'h11, 1'b1); push(1, 32'h22, 1'b1);
    cycle();
    cycle();
    chk("rr_tie_gnt", 64'(obs_gnt), 64'h1);
    chk("rr_tie_data", 64'(obs_od), 64'h11);
    cycle();
    chk("rr_next_gnt", 64'(obs_gnt), 64'h2);
    cycle();

    // Backpressure mid-burst.
    push(0, 32'hB0, 1'b0); push(0, 32'hB1, 1'b0); push(0, 32'hB2, 1'b1); push(1, 32'hC0, 1'b1);
    cycle();
    cycle();
    out_ready = 1'b0;
    repeat (4) begin
      cycle();
      chk("bp_gnt", 64'(obs_gnt), 64'h1);
      chk("bp_ready", 64'(obs_r0), 64'h0);
      chk("bp_data", 64'(obs_od), 64'hB1);
    end
    out_ready = 1'b1;
    cycle(); cycle();
    cycle();
    chk("bp_handover", 64'(obs_gnt), 64'h2);
    cycle();

    // Valid gap mid-burst with the other requester waiting.
    push(0, 32'hD0, 1'b0); push(0, 32'hD1, 1'b0); push(0, 32'hD2, 1'b1); push(1, 32'hE0, 1'b1);
    cycle();
    cycle();
    pres0 = 0;
    repeat (2) begin
      cycle();
      chk("gap_gnt", 64'(obs_gnt), 64'h1);
      chk("gap_valid", 64'(obs_ov), 64'h0);
    end
    pres0 = 1;
    cycle();
    chk("gap_data", 64'(obs_od), 64'hD1);
    cycle();
    cycle();
    chk("gap_handover", 64'(obs_od), 64'hE0);
    cycle();

    // Random traffic with an asynchronous reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      if (q0.size() == 0 && $urandom_range(0, 3) == 0) push_burst(0);
      if (q1.size() == 0 && $urandom_range(0, 3) == 0) push_burst(1);
      pres0 = hold0 ? 1'b1 : ($urandom_range(0, 3) != 0);
      pres1 = hold1 ? 1'b1 : ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (n == 1500) begin
        rst_n = 1'b0;
        owner = -1; rr = 1'b0; cnt = 0;
        #1;
        chk("async_reset_gnt", 64'(gnt), 64'h0);
        chk("async_reset_valid", 64'(out_valid), 64'h0);
      end
      if (n == 1503) rst_n = 1'b1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
